// File: rtl/spi_pkg.sv
// Shared encodings for the parametrised SPI master: FSM state codes and
// the four SPI modes expressed as {CPOL,CPHA}.
package spi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_TAIL  = 3'd4;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK timing core: half-period divider plus edge counter for one word.
// Strobes fire one cycle before the registered pins in the top change.
module spi_sck_gen #(
    parameter int HALF_DIV = 10,
    parameter int DATA_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic lead_edge,
    output logic trail_edge,
    output logic last_edge
);

    localparam int HW = $clog2(HALF_DIV);
    localparam int EW = $clog2(2 * DATA_W);

    logic [HW-1:0] half_q, half_d;
    logic [EW-1:0] edg_q, edg_d;
    logic          run_q, run_d;
    logic          tick_s;

    // Edge strobes and counter advance; edge count 0-based, even = leading.
    always_comb begin
        tick_s     = run_q && (half_q == HW'(HALF_DIV - 1));
        lead_edge  = tick_s && !edg_q[0];
        trail_edge = tick_s && edg_q[0];
        last_edge  = tick_s && (edg_q == EW'(2 * DATA_W - 1));
        half_d     = half_q;
        edg_d      = edg_q;
        run_d      = run_q;
        if (load) begin
            half_d = {HW{1'b0}};
            edg_d  = {EW{1'b0}};
            run_d  = 1'b1;
        end else if (tick_s) begin
            half_d = {HW{1'b0}};
            edg_d  = last_edge ? {EW{1'b0}} : edg_q + EW'(1);
            run_d  = !last_edge;
        end else if (run_q) begin
            half_d = half_q + HW'(1);
        end else begin
            half_d = half_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= {HW{1'b0}};
            edg_q  <= {EW{1'b0}};
            run_q  <= 1'b0;
        end else begin
            half_q <= half_d;
            edg_q  <= edg_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one word per start, optional back-to-back words
// under a single CS assertion via the done-cycle start / hold_cs handshake.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int HALF_DIV  = 10,
    parameter int CS_SETUP  = 20,
    parameter int CS_HOLD   = 20,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold_cs,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              cs_n,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    localparam int DLY_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    logic [2:0]        state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d, word_s;
    logic              mosi_q, mosi_d, sck_q, sck_d, cs_n_q, cs_n_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              accept_s, load_s, lead_s, trail_s, last_s;

    // Shift registers always run MSB-first; LSB-first words are mirrored.
    function automatic logic [DATA_W-1:0] order_bits(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = LSB_FIRST ? w[DATA_W-1-i] : w[i];
        end
        return r;
    endfunction

    spi_sck_gen #(
        .HALF_DIV (HALF_DIV),
        .DATA_W   (DATA_W)
    ) u_sck_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .lead_edge  (lead_s),
        .trail_edge (trail_s),
        .last_edge  (last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dly_q   <= {DLY_W{1'b0}};
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

    // Next-state logic; in SHIFT, done_q marks the decision cycle.
    always_comb begin
        accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_HOLD) ||
                             ((state_q == ST_SHIFT) && done_q));
        state_d  = state_q;
        case (state_q)
            ST_IDLE:  state_d = accept_s ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_d = (dly_q == DLY_W'(CS_SETUP - 1)) ? ST_SHIFT : ST_SETUP;
            ST_SHIFT: begin
                if (!done_q)       state_d = ST_SHIFT;
                else if (accept_s) state_d = ST_SHIFT;
                else if (hold_cs)  state_d = ST_HOLD;
                else               state_d = ST_TAIL;
            end
            ST_HOLD: begin
                if (accept_s)      state_d = ST_SHIFT;
                else if (!hold_cs) state_d = ST_TAIL;
                else               state_d = ST_HOLD;
            end
            ST_TAIL:  state_d = (dly_q == DLY_W'(CS_HOLD - 1)) ? ST_IDLE : ST_TAIL;
            default:  state_d = ST_IDLE;
        endcase
        load_s = (state_d == ST_SHIFT) && ((state_q != ST_SHIFT) || done_q);
        dly_d  = ((state_d == state_q) && ((state_q == ST_SETUP) || (state_q == ST_TAIL))) ?
                 dly_q + DLY_W'(1) : {DLY_W{1'b0}};
    end

    // Output and datapath next values.
    always_comb begin
        tx_d    = tx_q;
        rx_d    = rx_q;
        mosi_d  = mosi_q;
        sck_d   = sck_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        // A word accepted in IDLE waits in tx_q through SETUP.
        word_s  = (state_q == ST_SETUP) ? tx_q : order_bits(wdata);
        if (load_s) begin
            if (!CPHA) begin
                mosi_d = word_s[DATA_W-1];
                tx_d   = word_s << 1'b1;
            end else begin
                tx_d   = word_s;
            end
        end else if (accept_s) begin
            tx_d = word_s;
        end else if (lead_s) begin
            sck_d = ~sck_q;
            if (!CPHA) begin
                rx_d    = rx_q << 1'b1;
                rx_d[0] = miso;
            end else begin
                mosi_d = tx_q[DATA_W-1];
                tx_d   = tx_q << 1'b1;
            end
        end else if (trail_s) begin
            sck_d = ~sck_q;
            if (CPHA) begin
                rx_d    = rx_q << 1'b1;
                rx_d[0] = miso;
            end else if (!last_s) begin
                mosi_d = tx_q[DATA_W-1];
                tx_d   = tx_q << 1'b1;
            end else begin
                mosi_d = mosi_q;
            end
        end else begin
            tx_d = tx_q;
        end
        if (last_s) begin
            done_d  = 1'b1;
            rdata_d = order_bits(rx_d);
        end else begin
            done_d  = 1'b0;
        end
        if (state_d == ST_IDLE) begin
            mosi_d = 1'b0;
            sck_d  = CPOL;
        end else begin
            sck_d  = sck_d;
        end
        cs_n_d = (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    // Pin and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q    <= {DATA_W{1'b0}};
            rx_q    <= {DATA_W{1'b0}};
            rdata_q <= {DATA_W{1'b0}};
            mosi_q  <= 1'b0;
            sck_q   <= CPOL;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            mosi_q  <= mosi_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign cs_n  = cs_n_q;
    assign sck   = sck_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: three instances (mode 0 loopback,
// mode 3 with a slave model, 16-bit LSB-first loopback) and a rdata scoreboard.
module tb_spi_master_param;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       a_start = 1'b0, a_hold = 1'b0;
    logic [7:0] a_wdata = 8'h00, a_rdata;
    logic       a_done, a_busy, a_cs_n, a_sck, a_mosi;
    logic       b_start = 1'b0, b_hold = 1'b0;
    logic [7:0] b_wdata = 8'h00, b_rdata;
    logic       b_done, b_busy, b_cs_n, b_sck, b_mosi;
    logic       b_miso = 1'b0;
    logic        c_start = 1'b0, c_hold = 1'b0;
    logic [15:0] c_wdata = 16'h0000, c_rdata;
    logic        c_done, c_busy, c_cs_n, c_sck, c_mosi;

    spi_master_param u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .hold_cs(a_hold), .wdata(a_wdata),
        .rdata(a_rdata), .done(a_done), .busy(a_busy), .cs_n(a_cs_n), .sck(a_sck),
        .mosi(a_mosi), .miso(a_mosi));

    spi_master_param #(.DATA_W(8), .HALF_DIV(4), .CS_SETUP(3), .CS_HOLD(3),
                       .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .hold_cs(b_hold), .wdata(b_wdata),
        .rdata(b_rdata), .done(b_done), .busy(b_busy), .cs_n(b_cs_n), .sck(b_sck),
        .mosi(b_mosi), .miso(b_miso));

    spi_master_param #(.DATA_W(16), .HALF_DIV(2), .CS_SETUP(2), .CS_HOLD(2),
                       .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .hold_cs(c_hold), .wdata(c_wdata),
        .rdata(c_rdata), .done(c_done), .busy(c_busy), .cs_n(c_cs_n), .sck(c_sck),
        .mosi(c_mosi), .miso(c_mosi));

    // Mode-3 slave: shifts 0x3C out MSB-first on each falling sck edge.
    logic [7:0] slv_word = 8'h3C;
    int         slv_idx = 0;
    always @(negedge b_sck or posedge b_cs_n) begin
        if (b_cs_n) begin
            slv_idx <= 0;
        end else begin
            b_miso  <= slv_word[7 - slv_idx];
            slv_idx <= slv_idx + 1;
        end
    end

    int n_assert = 0, n_fail = 0, cyc = 0;
    logic [15:0] qa[$], qb[$], qc[$];
    int a_rise = 0, a_rise_cyc = 0, a_dones = 0, a_done_cyc = 0, a_cs_hi = 0;
    int b_rise = 0, b_dones = 0, b_done_cyc = 0;
    int c_rise = 0, c_dones = 0, c_done_cyc = 0;
    logic a_win = 1'b0;
    logic a_sck_p = 1'b0, b_sck_p = 1'b1, c_sck_p = 1'b0;
    logic [15:0] a_bits = 16'h0, b_bits = 16'h0, c_bits = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample on the falling clk edge, update monitors, check scoreboard.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (a_sck === 1'b1 && a_sck_p === 1'b0) begin
            a_rise++; a_rise_cyc = cyc; a_bits = {a_bits[14:0], a_mosi};
        end
        a_sck_p = a_sck;
        if (a_win && a_cs_n !== 1'b0) a_cs_hi++;
        if (a_done === 1'b1) begin
            a_dones++; a_done_cyc = cyc;
            check("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) check("a_rdata", 32'(a_rdata), 32'(qa.pop_front()));
        end
        if (b_sck === 1'b1 && b_sck_p === 1'b0) begin
            b_rise++; b_bits = {b_bits[14:0], b_mosi};
        end
        b_sck_p = b_sck;
        if (b_done === 1'b1) begin
            b_dones++; b_done_cyc = cyc;
            check("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) check("b_rdata", 32'(b_rdata), 32'(qb.pop_front()));
        end
        if (c_sck === 1'b1 && c_sck_p === 1'b0) begin
            c_rise++; c_bits = {c_mosi, c_bits[15:1]};
        end
        c_sck_p = c_sck;
        if (c_done === 1'b1) begin
            c_dones++; c_done_cyc = cyc;
            check("c_sb_nonempty", 32'(qc.size() != 0), 32'd1);
            if (qc.size() != 0) check("c_rdata", 32'(c_rdata), 32'(qc.pop_front()));
        end
    endtask

    function automatic logic done_of(input int inst);
        case (inst)
            0:       return a_done;
            1:       return b_done;
            default: return c_done;
        endcase
    endfunction

    function automatic logic cs_of(input int inst);
        case (inst)
            0:       return a_cs_n;
            1:       return b_cs_n;
            default: return c_cs_n;
        endcase
    endfunction

    task automatic wait_done(input int inst, input int bound, input string tag);
        int k = 0;
        while (done_of(inst) !== 1'b1 && k < bound) begin tick(); k++; end
        check(tag, 32'(done_of(inst)), 32'd1);
    endtask

    task automatic wait_cs_high(input int inst, input int bound, input string tag);
        int k = 0;
        while (cs_of(inst) !== 1'b1 && k < bound) begin tick(); k++; end
        check(tag, 32'(cs_of(inst)), 32'd1);
    endtask

    initial begin
        int s, k, d, dones0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_a_cs_n", 32'(a_cs_n), 32'd1);
        check("rst_a_sck", 32'(a_sck), 32'd0);
        check("rst_a_mosi", 32'(a_mosi), 32'd0);
        check("rst_a_rdata", 32'(a_rdata), 32'd0);
        check("rst_a_done", 32'(a_done), 32'd0);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_b_sck", 32'(b_sck), 32'd1);
        rst_n = 1'b1;
        repeat (2) tick();

        // Mode 0 loopback, 0xA5: latency, edge count and CS timing.
        a_rise = 0; a_wdata = 8'hA5; a_hold = 1'b0; a_start = 1'b1; qa.push_back(16'h00A5);
        s = cyc;
        tick(); a_start = 1'b0;
        check("a_cs_fall", 32'(a_cs_n), 32'd0);
        check("a_busy_rise", 32'(a_busy), 32'd1);
        k = 0;
        while (a_rise < 1 && k < 100) begin tick(); k++; end
        check("a_first_edge", 32'(a_rise_cyc - s), 32'd31);
        wait_done(0, 400, "a_done_seen");
        check("a_done_latency", 32'(a_done_cyc - s), 32'd181);
        check("a_rises", 32'(a_rise), 32'd8);
        check("a_mosi_word", 32'(a_bits[7:0]), 32'hA5);
        d = a_done_cyc;
        tick();
        wait_cs_high(0, 100, "a_cs_rise_seen");
        check("a_cs_rise_time", 32'(cyc - d), 32'd21);
        check("a_busy_fall", 32'(a_busy), 32'd0);
        check("a_mosi_idle", 32'(a_mosi), 32'd0);
        repeat (2) tick();

        // Mode 3 with slave returning 0x3C while sending 0x9F.
        b_rise = 0; b_wdata = 8'h9F; b_start = 1'b1; qb.push_back(16'h003C);
        s = cyc;
        tick(); b_start = 1'b0;
        wait_done(1, 200, "b_done_seen");
        check("b_done_latency", 32'(b_done_cyc - s), 32'd68);
        check("b_mosi_word", 32'(b_bits[7:0]), 32'h9F);
        check("b_rises", 32'(b_rise), 32'd8);
        check("b_sck_at_done", 32'(b_sck), 32'd1);
        tick();
        wait_cs_high(1, 50, "b_cs_rise_seen");
        check("b_cs_rise_time", 32'(cyc - b_done_cyc), 32'd4);
        check("b_sck_idle", 32'(b_sck), 32'd1);

        // Three words under one CS: back-to-back, then via HOLD.
        a_rise = 0; a_dones = 0; a_cs_hi = 0;
        a_wdata = 8'h03; a_hold = 1'b1; a_start = 1'b1; qa.push_back(16'h0003);
        tick(); a_start = 1'b0; a_win = 1'b1;
        wait_done(0, 400, "a_w1_done");
        d = cyc; a_wdata = 8'h00; a_start = 1'b1; qa.push_back(16'h0000);
        tick(); a_start = 1'b0;
        k = 0;
        while (a_rise < 9 && k < 100) begin tick(); k++; end
        check("a_b2b_first_edge", 32'(a_rise_cyc - d), 32'd11);
        wait_done(0, 400, "a_w2_done");
        repeat (5) tick();
        check("a_hold_sck", 32'(a_sck), 32'd0);
        check("a_hold_busy", 32'(a_busy), 32'd1);
        a_wdata = 8'h10; a_start = 1'b1; qa.push_back(16'h0010);
        tick(); a_start = 1'b0; a_hold = 1'b0;
        wait_done(0, 400, "a_w3_done");
        d = cyc; a_win = 1'b0;
        tick();
        wait_cs_high(0, 100, "a_seq_cs_rise_seen");
        check("a_seq_cs_rise_time", 32'(cyc - d), 32'd21);
        check("a_seq_cs_low", 32'(a_cs_hi), 32'd0);
        check("a_seq_dones", 32'(a_dones), 32'd3);
        check("a_seq_rises", 32'(a_rise), 32'd24);
        tick();

        // 16-bit LSB-first loopback.
        c_rise = 0; c_wdata = 16'h1234; c_start = 1'b1; qc.push_back(16'h1234);
        s = cyc;
        tick(); c_start = 1'b0;
        wait_done(2, 200, "c_done_seen");
        check("c_done_latency", 32'(c_done_cyc - s), 32'd67);
        check("c_mosi_order", 32'(c_bits), 32'h1234);
        check("c_rises", 32'(c_rise), 32'd16);
        tick();
        wait_cs_high(2, 50, "c_cs_rise_seen");

        // start during SHIFT must be ignored.
        dones0 = a_dones;
        a_wdata = 8'h5A; a_start = 1'b1; qa.push_back(16'h005A);
        tick(); a_start = 1'b0;
        repeat (50) tick();
        a_wdata = 8'hFF; a_start = 1'b1;
        tick(); a_start = 1'b0; a_wdata = 8'h00;
        wait_done(0, 400, "a_ign_done");
        check("a_ign_mosi_word", 32'(a_bits[7:0]), 32'h5A);
        tick();
        wait_cs_high(0, 100, "a_ign_cs_rise");
        repeat (5) tick();
        check("a_ign_idle", 32'(a_busy), 32'd0);
        check("a_ign_dones", 32'(a_dones - dones0), 32'd1);

        // Reset in the middle of SHIFT, then a clean word.
        dones0 = a_dones;
        a_wdata = 8'hC3; a_start = 1'b1;
        tick(); a_start = 1'b0;
        repeat (60) tick();
        rst_n = 1'b0;
        #1;
        check("a_mid_rst_cs_n", 32'(a_cs_n), 32'd1);
        check("a_mid_rst_sck", 32'(a_sck), 32'd0);
        check("a_mid_rst_mosi", 32'(a_mosi), 32'd0);
        check("a_mid_rst_busy", 32'(a_busy), 32'd0);
        check("a_mid_rst_done", 32'(a_done), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (200) tick();
        check("a_mid_rst_no_done", 32'(a_dones - dones0), 32'd0);
        a_wdata = 8'h3C; a_start = 1'b1; qa.push_back(16'h003C);
        s = cyc;
        tick(); a_start = 1'b0;
        wait_done(0, 400, "a_post_rst_done");
        check("a_post_rst_latency", 32'(a_done_cyc - s), 32'd181);
        check("a_sb_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
